// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy defuzzification stage.
// Q1.15 limits and the percent scaling constants live here so the top and bench agree.
package fuzzy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        SCALE,
        DONE
    } defuzz_state_t;

    localparam logic [15:0] Q15_MAX   = 16'd32767;
    localparam int          PCT_SCALE = 100;
    localparam int          Q15_HALF  = 16384;

endpackage

// File: rtl/q15_restoring_div.sv
// Restoring divider datapath: one quotient bit per clock, MSB first.
// The caller guarantees num < den, so the quotient is a pure fraction.
module q15_restoring_div #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] num,
    input  logic [DATA_W-1:0] den_in,
    output logic              done,
    output logic [DATA_W-1:0] q
);

    localparam int CNT_W = $clog2(FRAC_W + 1);

    logic [DATA_W:0]   rem;
    logic [DATA_W:0]   r2;
    logic [DATA_W:0]   rem_nxt;
    logic [DATA_W-1:0] den;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              q_bit;

    // rem < den always holds, so the doubled remainder fits in DATA_W+1 bits
    always_comb begin
        r2      = {rem[DATA_W-1:0], 1'b0};
        q_bit   = (r2 >= {1'b0, den});
        rem_nxt = q_bit ? (r2 - {1'b0, den}) : r2;
    end

    assign done = busy && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            den  <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rem  <= {1'b0, num};
            den  <= den_in;
            q    <= '0;
            cnt  <= CNT_W'(FRAC_W - 1);
            busy <= 1'b1;
        end else if (busy) begin
            rem <= rem_nxt;
            q   <= {q[DATA_W-2:0], q_bit};
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/defuzz_centroid_div.sv
// Centroid defuzzifier: y = S_wg / S_w in Q1.15 plus a rounded percent value.
// Degenerate pairs (S_w == 0 or quotient >= 1) bypass the divider and finish in one edge.
module defuzz_centroid_div
    import fuzzy_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 15,
    parameter int PCT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] S_w,
    input  logic [DATA_W-1:0] S_wg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y_q15,
    output logic [PCT_W-1:0]  y_pct,
    output logic              div0
);

    // Inputs are unsigned Q1.15; anything with bit 15 set is above 1.0 and is clamped
    function automatic logic [DATA_W-1:0] clamp_q15(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}} : v;
    endfunction

    function automatic logic [PCT_W-1:0] pct_round(input logic [DATA_W-1:0] v);
        logic [23:0] acc;
        acc = 24'(v) * 24'(PCT_SCALE) + 24'(Q15_HALF);
        return PCT_W'(acc >> FRAC_W);
    endfunction

    defuzz_state_t     state;
    logic [DATA_W-1:0] sw_c;
    logic [DATA_W-1:0] swg_c;
    logic              accept;
    logic              div_start;
    logic              div_done;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] q_fix;
    logic              use_fix;
    logic              flag_div0;
    logic [DATA_W-1:0] q_res;

    always_comb begin
        sw_c      = clamp_q15(S_w);
        swg_c     = clamp_q15(S_wg);
        accept    = (state == IDLE) && in_valid;
        div_start = accept && (sw_c != '0) && (swg_c < sw_c);
        q_res     = use_fix ? q_fix : div_q;
    end

    assign in_ready = (state == IDLE);

    q15_restoring_div #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start),
        .num    (swg_c),
        .den_in (sw_c),
        .done   (div_done),
        .q      (div_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            y_q15     <= '0;
            y_pct     <= '0;
            div0      <= 1'b0;
            q_fix     <= '0;
            use_fix   <= 1'b0;
            flag_div0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sw_c == '0) begin
                            q_fix     <= '0;
                            use_fix   <= 1'b1;
                            flag_div0 <= 1'b1;
                            state     <= SCALE;
                        end else if (swg_c >= sw_c) begin
                            q_fix     <= DATA_W'(Q15_MAX);
                            use_fix   <= 1'b1;
                            flag_div0 <= 1'b0;
                            state     <= SCALE;
                        end else begin
                            use_fix   <= 1'b0;
                            flag_div0 <= 1'b0;
                            state     <= DIV;
                        end
                    end
                end
                DIV: begin
                    if (div_done) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    y_q15     <= q_res;
                    y_pct     <= pct_round(q_res);
                    div0      <= flag_div0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_defuzz_centroid_div.sv
// Directed and randomized bench for defuzz_centroid_div against an arithmetic reference.
module tb_defuzz_centroid_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] S_w;
    logic [15:0] S_wg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y_q15;
    logic [7:0]  y_pct;
    logic        div0;

    int checks = 0;
    int errors = 0;

    defuzz_centroid_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S_w       (S_w),
        .S_wg      (S_wg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_q15     (y_q15),
        .y_pct     (y_pct),
        .div0      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: clamp, then the exact rational floor(S_wg*2^15/S_w) with the saturation rules
    task automatic model(input longint sw, input longint swg,
                         output longint y, output longint pct, output longint d0, output longint lat);
        longint a;
        longint b;
        a = (sw > 32767) ? 32767 : sw;
        b = (swg > 32767) ? 32767 : swg;
        if (a == 0) begin
            y = 0; d0 = 1; lat = 1;
        end else if (b >= a) begin
            y = 32767; d0 = 0; lat = 1;
        end else begin
            y = (b * 32768) / a; d0 = 0; lat = 16;
        end
        pct = (y * 100 + 16384) / 32768;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_txn(input logic [15:0] sw, input logic [15:0] swg);
        longint ey, ep, ed, el;
        int lat;
        model(longint'(sw), longint'(swg), ey, ep, ed, el);
        @(negedge clk);
        S_w = sw; S_wg = swg; in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        S_w = 16'($urandom); S_wg = 16'($urandom);
        wait_result(lat);
        check("latency", 32'(lat), 32'(el));
        check("y_q15", 32'(y_q15), 32'(ey));
        check("y_pct", 32'(y_pct), 32'(ep));
        check("div0", 32'(div0), 32'(ed));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("y_q15_kept", 32'(y_q15), 32'(ey));
        out_ready = 1'b0;
    endtask

    initial begin
        longint ey, ep, ed, el;
        int lat;
        int stale;
        logic [15:0] rw, rg;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S_w = '0; S_wg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y_q15", 32'(y_q15), 32'd0);
        check("rst_y_pct", 32'(y_pct), 32'd0);
        check("rst_div0", 32'(div0), 32'd0);
        @(negedge clk); rst = 1'b0;

        run_txn(16'd32767, 16'd16384);
        run_txn(16'd20000, 16'd5000);
        run_txn(16'd20000, 16'd19999);
        run_txn(16'd1000, 16'd1000);
        run_txn(16'd1000, 16'd3000);
        run_txn(16'd0, 16'd500);
        run_txn(16'd20000, 16'd5000);
        run_txn(16'hFFFF, 16'd16384);
        run_txn(16'd30000, 16'h8001);
        run_txn(16'd1, 16'd0);

        // Backpressure: result held while out_ready stays low, busy inputs ignored
        model(64'd20000, 64'd5000, ey, ep, ed, el);
        @(negedge clk); S_w = 16'd20000; S_wg = 16'd5000; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'(el));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); S_w = 16'd0; S_wg = 16'd7; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_y_q15", 32'(y_q15), 32'(ey));
            check("bp_y_pct", 32'(y_pct), 32'(ep));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_ghost", 32'(out_valid), 32'd0);
        check("bp_div0_kept", 32'(div0), 32'd0);

        // Asynchronous reset in the middle of a division
        run_txn(16'd1000, 16'd3000);
        @(negedge clk); S_w = 16'd20000; S_wg = 16'd5000; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_y_q15", 32'(y_q15), 32'd0);
        check("arst_y_pct", 32'(y_pct), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        stale = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) stale++;
        end
        check("arst_no_stale", 32'(stale), 32'd0);
        run_txn(16'd20000, 16'd19999);

        // Randomized pairs, mostly proper fractions, some clamped or saturated
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 3) begin
                rw = 16'($urandom);
                rg = 16'($urandom);
            end else begin
                rw = 16'($urandom_range(1, 32767));
                rg = 16'($urandom_range(0, int'(rw) - 1));
            end
            run_txn(rw, rg);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
